// File: rtl/if_stage_pkg.sv
// Shared LC-3b types for the fetch stage: machine word and fetch FSM states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } if_state_t;

    localparam lc3b_word PC_STEP = 16'd2;

    // Instructions are halfword aligned; the low address bit is never used.
    function automatic lc3b_word align_pc(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/if_stage_skid_buffer.sv
// One-entry {ir, pc} holding register that catches a fetched instruction
// while the IF/ID latch is stalled.
import lc3b_types::*;

module if_skid_buffer (
    input  logic     clk,
    input  logic     reset,
    input  logic     load_i,
    input  logic     clear_i,
    input  lc3b_word ir_i,
    input  lc3b_word pc_i,
    output logic     valid_o,
    output lc3b_word ir_o,
    output lc3b_word pc_o
);

    logic     valid_q;
    lc3b_word ir_q;
    lc3b_word pc_q;

    // Clear wins over load; the two are never requested together by the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ir_q    <= ir_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign ir_o    = ir_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// LC-3b instruction fetch stage: PC, hold-until-resp memory requests,
// IF/ID latch, one-entry skid for stall, and redirect with in-flight discard.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | no read outstanding
// BUSY    | read outstanding, result will be kept
// DISCARD | read outstanding, result will be dropped
import lc3b_types::*;

module if_stage #(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    output lc3b_word imem_address,
    output logic     imem_read,
    input  logic     imem_resp,
    input  lc3b_word imem_rdata,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output logic     id_valid,
    output lc3b_word id_ir,
    output lc3b_word id_pc
);

    if_state_t state_q, state_d;
    lc3b_word  pc_q, pc_d;
    lc3b_word  addr_q, addr_d;
    logic      id_valid_q, id_valid_d;
    lc3b_word  id_ir_q, id_ir_d;
    lc3b_word  id_pc_q, id_pc_d;

    logic      skid_valid;
    lc3b_word  skid_ir;
    lc3b_word  skid_pc;
    logic      skid_load;
    logic      skid_clear;

    lc3b_word  pc_plus2;
    lc3b_word  target_pc;
    logic      accept;
    logic      latch_open;

    assign pc_plus2   = pc_q + PC_STEP;
    assign target_pc  = align_pc(redirect_pc);
    assign accept     = (state_q == BUSY) && imem_resp && !redirect;
    assign latch_open = !stall || !id_valid_q;

    // Next-state, PC, latch and skid control; redirect overrides everything but reset.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        id_valid_d = id_valid_q;
        id_ir_d    = id_ir_q;
        id_pc_d    = id_pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (redirect) begin
            id_valid_d = 1'b0;
            skid_clear = 1'b1;
            pc_d       = target_pc;
            // A read that completes on this edge is simply dropped, so the
            // new target can be issued immediately.
            if (state_q == IDLE || imem_resp) begin
                state_d = BUSY;
                addr_d  = target_pc;
            end else begin
                state_d = DISCARD;
            end
        end else begin
            if (latch_open) begin
                if (skid_valid) begin
                    id_valid_d = 1'b1;
                    id_ir_d    = skid_ir;
                    id_pc_d    = skid_pc;
                    skid_clear = 1'b1;
                end else if (accept) begin
                    id_valid_d = 1'b1;
                    id_ir_d    = imem_rdata;
                    id_pc_d    = pc_plus2;
                end else begin
                    id_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_load = 1'b1;
            end

            if (accept) begin
                pc_d = pc_plus2;
            end

            case (state_q)
                IDLE: begin
                    // In IDLE the skid is never loaded, so it is empty after
                    // this edge unless it was full and not drained.
                    if (!skid_valid || skid_clear) begin
                        state_d = BUSY;
                        addr_d  = pc_q;
                    end
                end
                BUSY: begin
                    if (imem_resp) begin
                        if (skid_load) begin
                            state_d = IDLE;
                        end else begin
                            state_d = BUSY;
                            addr_d  = pc_plus2;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        state_d = BUSY;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, PC, address and IF/ID latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            id_valid_q <= 1'b0;
            id_ir_q    <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            id_valid_q <= id_valid_d;
            id_ir_q    <= id_ir_d;
            id_pc_q    <= id_pc_d;
        end
    end

    if_skid_buffer u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ir_i    (imem_rdata),
        .pc_i    (pc_plus2),
        .valid_o (skid_valid),
        .ir_o    (skid_ir),
        .pc_o    (skid_pc)
    );

    assign imem_address = addr_q;
    assign imem_read    = (state_q != IDLE);
    assign id_valid     = id_valid_q;
    assign id_ir        = id_ir_q;
    assign id_pc        = id_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. Inputs are driven and outputs
// checked just after the falling edge; state changes on the rising edge.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [15:0] imem_address;
    logic        imem_read;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_ir;
    logic [15:0] id_pc;

    // mem_en selects a same-cycle responding memory; otherwise man_* drive the bus.
    logic        mem_en;
    logic        man_resp;
    logic [15:0] man_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] memval(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0002: return 16'h5678;
            default:  return a ^ 16'hA5A5;
        endcase
    endfunction

    assign imem_resp  = mem_en ? imem_read : man_resp;
    assign imem_rdata = mem_en ? memval(imem_address) : man_rdata;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ir        (id_ir),
        .id_pc        (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        mem_en = 1'b1; man_resp = 1'b0; man_rdata = 16'h0000;
        step(); step();
        n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", imem_read); end
        n_checks++; if (imem_address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", imem_address); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_checks++; if (id_ir !== 16'h0000 || id_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_latch: got ir=%h pc=%h want 0000/0000", id_ir, id_pc); end
        reset = 1'b0;
        step();
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin n_fail++; $display("FAIL first_read: got read=%b addr=%h want 1/0000", imem_read, imem_address); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL first_read_valid: got %b want 0", id_valid); end
    endtask

    task automatic test_stream();
        step();
        n_checks++; if (id_valid !== 1'b1 || id_ir !== 16'h1234 || id_pc !== 16'h0002) begin n_fail++; $display("FAIL stream0: got v=%b ir=%h pc=%h want 1/1234/0002", id_valid, id_ir, id_pc); end
        n_checks++; if (imem_address !== 16'h0002 || imem_read !== 1'b1) begin n_fail++; $display("FAIL stream0_addr: got addr=%h read=%b want 0002/1", imem_address, imem_read); end
        step();
        n_checks++; if (id_valid !== 1'b1 || id_ir !== 16'h5678 || id_pc !== 16'h0004) begin n_fail++; $display("FAIL stream1: got v=%b ir=%h pc=%h want 1/5678/0004", id_valid, id_ir, id_pc); end
        n_checks++; if (imem_address !== 16'h0004) begin n_fail++; $display("FAIL stream1_addr: got %h want 0004", imem_address); end
    endtask

    task automatic test_stall_skid();
        mem_en = 1'b0; man_resp = 1'b0; stall = 1'b1;
        step();
        n_checks++; if (id_ir !== 16'h5678 || id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got v=%b ir=%h want 1/5678", id_valid, id_ir); end
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0004) begin n_fail++; $display("FAIL stall_req: got read=%b addr=%h want 1/0004", imem_read, imem_address); end
        man_resp = 1'b1; man_rdata = 16'h9ABC;
        step();
        man_resp = 1'b0;
        n_checks++; if (id_ir !== 16'h5678 || id_pc !== 16'h0004 || id_valid !== 1'b1) begin n_fail++; $display("FAIL skid_hold: got v=%b ir=%h pc=%h want 1/5678/0004", id_valid, id_ir, id_pc); end
        n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL skid_no_read: got %b want 0", imem_read); end
        step();
        n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL skid_no_read2: got %b want 0", imem_read); end
        stall = 1'b0;
        step();
        n_checks++; if (id_valid !== 1'b1 || id_ir !== 16'h9ABC || id_pc !== 16'h0006) begin n_fail++; $display("FAIL skid_drain: got v=%b ir=%h pc=%h want 1/9abc/0006", id_valid, id_ir, id_pc); end
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0006) begin n_fail++; $display("FAIL skid_resume: got read=%b addr=%h want 1/0006", imem_read, imem_address); end
    endtask

    task automatic test_redirect_outstanding();
        redirect = 1'b1; redirect_pc = 16'h3000;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0006) begin n_fail++; $display("FAIL disc_hold0: got read=%b addr=%h want 1/0006", imem_read, imem_address); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL disc_flush: got %b want 0", id_valid); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0006) begin n_fail++; $display("FAIL disc_hold%0d: got read=%b addr=%h want 1/0006", i + 1, imem_read, imem_address); end
        end
        man_resp = 1'b1; man_rdata = 16'hDEAD;
        step();
        man_resp = 1'b0;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL disc_drop: got %b want 0", id_valid); end
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h3000) begin n_fail++; $display("FAIL disc_refetch: got read=%b addr=%h want 1/3000", imem_read, imem_address); end
    endtask

    task automatic test_redirect_same_cycle();
        man_resp = 1'b1; man_rdata = 16'hBEEF; redirect = 1'b1; redirect_pc = 16'h4001;
        step();
        man_resp = 1'b0; redirect = 1'b0;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL same_drop: got %b want 0", id_valid); end
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h4000) begin n_fail++; $display("FAIL same_refetch: got read=%b addr=%h want 1/4000", imem_read, imem_address); end
        man_resp = 1'b1; man_rdata = 16'h1111;
        step();
        stall = 1'b1; man_rdata = 16'h2222;
        step();
        man_resp = 1'b0;
        n_checks++; if (id_ir !== 16'h1111 || id_pc !== 16'h4002 || imem_read !== 1'b0) begin n_fail++; $display("FAIL stall_setup: got ir=%h pc=%h read=%b want 1111/4002/0", id_ir, id_pc, imem_read); end
        redirect = 1'b1; redirect_pc = 16'h5000;
        step();
        redirect = 1'b0;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_redir_valid: got %b want 0", id_valid); end
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h5000) begin n_fail++; $display("FAIL stall_redir_addr: got read=%b addr=%h want 1/5000", imem_read, imem_address); end
        stall = 1'b0; man_resp = 1'b1; man_rdata = 16'h5555;
        step();
        man_resp = 1'b0;
        n_checks++; if (id_valid !== 1'b1 || id_ir !== 16'h5555 || id_pc !== 16'h5002) begin n_fail++; $display("FAIL skid_cleared: got v=%b ir=%h pc=%h want 1/5555/5002", id_valid, id_ir, id_pc); end
        n_checks++; if (imem_address !== 16'h5002) begin n_fail++; $display("FAIL after_clear_addr: got %h want 5002", imem_address); end
    endtask

    task automatic test_wrap();
        man_resp = 1'b1; man_rdata = 16'h0BAD; redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0; man_rdata = 16'h7777;
        n_checks++; if (imem_address !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr: got %h want fffe", imem_address); end
        step();
        man_resp = 1'b0;
        n_checks++; if (id_valid !== 1'b1 || id_ir !== 16'h7777 || id_pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_latch: got v=%b ir=%h pc=%h want 1/7777/0000", id_valid, id_ir, id_pc); end
        n_checks++; if (imem_address !== 16'h0000 || imem_read !== 1'b1) begin n_fail++; $display("FAIL wrap_next: got addr=%h read=%b want 0000/1", imem_address, imem_read); end
    endtask

    task automatic test_reset_mid_discard();
        man_resp = 1'b1; man_rdata = 16'h8888;
        step();
        man_resp = 1'b0; redirect = 1'b1; redirect_pc = 16'h2000;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0002 || id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_disc: got read=%b addr=%h v=%b want 1/0002/0", imem_read, imem_address, id_valid); end
        reset = 1'b1;
        step();
        n_checks++; if (imem_read !== 1'b0 || imem_address !== 16'h0000) begin n_fail++; $display("FAIL rst_disc_req: got read=%b addr=%h want 0/0000", imem_read, imem_address); end
        n_checks++; if (id_valid !== 1'b0 || id_ir !== 16'h0000 || id_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_disc_latch: got v=%b ir=%h pc=%h want 0/0000/0000", id_valid, id_ir, id_pc); end
        reset = 1'b0;
        step();
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin n_fail++; $display("FAIL rst_restart: got read=%b addr=%h want 1/0000", imem_read, imem_address); end
        man_resp = 1'b1; man_rdata = 16'h1234;
        step();
        man_resp = 1'b0;
        n_checks++; if (id_valid !== 1'b1 || id_ir !== 16'h1234 || id_pc !== 16'h0002) begin n_fail++; $display("FAIL rst_first: got v=%b ir=%h pc=%h want 1/1234/0002", id_valid, id_ir, id_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_outstanding();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid_discard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
